// File: rtl/mc_alu_if.sv
// Request/response bundle of the multi-cycle ALU: operation request in,
// registered result and busy/ready status out.
interface mc_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       ALUOp;
    logic             out_valid;
    logic [WIDTH-1:0] C;
    logic             Zero;
    logic             busy;

    modport master (
        output in_valid, flush, A, B, ALUOp,
        input  in_ready, out_valid, C, Zero, busy
    );

    modport slave (
        input  in_valid, flush, A, B, ALUOp,
        output in_ready, out_valid, C, Zero, busy
    );
endinterface

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops plus iterative
// shift-add multiply and restoring divide over operand magnitudes.
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic   clk,
    input logic   rstn,
    mc_alu_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [4:0] OP_LUI    = 5'd1,  OP_AUIPC  = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB    = 5'd4,  OP_SLL    = 5'd5,  OP_SLT  = 5'd6;
    localparam logic [4:0] OP_SLTU   = 5'd7,  OP_XOR    = 5'd8,  OP_SRL  = 5'd9;
    localparam logic [4:0] OP_SRA    = 5'd10, OP_OR     = 5'd11, OP_AND  = 5'd12;
    localparam logic [4:0] OP_MUL    = 5'd13, OP_MULH   = 5'd14, OP_MULHSU = 5'd15;
    localparam logic [4:0] OP_MULHU  = 5'd16, OP_DIV    = 5'd17, OP_DIVU = 5'd18;
    localparam logic [4:0] OP_REM    = 5'd19, OP_REMU   = 5'd20;

    typedef enum logic {IDLE, ITER} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a, b, alu_res, corner_res, res1;
    logic [SH_W-1:0]  shamt;
    logic [4:0]       op;
    logic             is_mul, is_div, is_sdiv, b_zero, ovf, corner;
    logic             a_signed, b_signed, neg_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             accept, start_iter, step_last;

    logic [4:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic [WIDTH-1:0] acc, q, d;
    logic [WIDTH-1:0] acc_n, q_n, fin;
    logic             out_valid, zero;
    logic [WIDTH-1:0] c_r;

    assign a     = bus.A;
    assign b     = bus.B;
    assign op    = bus.ALUOp;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        alu_res = '1;
        case (op)
            OP_LUI:   alu_res = b;
            OP_AUIPC,
            OP_ADD:   alu_res = a + b;
            OP_SUB:   alu_res = a - b;
            OP_SLL:   alu_res = a << shamt;
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_XOR:   alu_res = a ^ b;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = WIDTH'($signed(a) >>> shamt);
            OP_OR:    alu_res = a | b;
            OP_AND:   alu_res = a & b;
            default:  alu_res = '1;
        endcase
    end

    assign is_mul  = (op >= OP_MUL) && (op <= OP_MULHU);
    assign is_div  = (op >= OP_DIV) && (op <= OP_REMU);
    assign is_sdiv = (op == OP_DIV) || (op == OP_REM);
    assign b_zero  = (b == '0);
    assign ovf     = is_sdiv && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign corner  = is_div && (b_zero || ovf);

    // Divide-by-zero takes precedence; the overflow case only applies to B = -1.
    always_comb begin
        corner_res = '0;
        if (b_zero)
            corner_res = (op == OP_DIV || op == OP_DIVU) ? '1 : a;
        else
            corner_res = (op == OP_DIV) ? a : '0;
    end

    assign res1 = is_div ? corner_res : alu_res;

    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || is_sdiv;
    assign b_signed = (op == OP_MULH) || is_sdiv;
    assign mag_a    = (a_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b    = (b_signed && b[WIDTH-1]) ? -b : b;

    // Sign to re-apply at the end: product/quotient follow A^B, remainder follows A.
    always_comb begin
        neg_in = 1'b0;
        case (op)
            OP_MULH,
            OP_DIV:   neg_in = a[WIDTH-1] ^ b[WIDTH-1];
            OP_MULHSU,
            OP_REM:   neg_in = a[WIDTH-1];
            default:  neg_in = 1'b0;
        endcase
    end

    assign accept     = bus.in_valid && bus.in_ready && !bus.flush;
    assign start_iter = accept && (is_mul || (is_div && !corner));
    assign step_last  = (state == ITER) && (cnt == CNT_W'(WIDTH-1));

    // One iteration step: mul keeps {acc,q} as the shifting product,
    // div keeps acc as partial remainder and q as dividend/quotient.
    logic [WIDTH:0]   sum, r_sh;
    logic [WIDTH+1:0] diff;
    always_comb begin
        sum   = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
        r_sh  = {acc, q[WIDTH-1]};
        diff  = {1'b0, r_sh} - {2'b00, d};
        acc_n = acc;
        q_n   = q;
        if ((op_q >= OP_MUL) && (op_q <= OP_MULHU)) begin
            acc_n = sum[WIDTH:1];
            q_n   = {sum[0], q[WIDTH-1:1]};
        end else if (!diff[WIDTH+1]) begin
            acc_n = diff[WIDTH-1:0];
            q_n   = {q[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = r_sh[WIDTH-1:0];
            q_n   = {q[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod, prod_s;
    always_comb begin
        prod   = {acc_n, q_n};
        prod_s = neg ? -prod : prod;
        case (op_q)
            OP_MUL:             fin = prod_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:           fin = prod_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:    fin = neg ? -q_n : q_n;
            default:            fin = neg ? -acc_n : acc_n;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_iter) state_nxt = ITER;
            ITER:    if (bus.flush || step_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            c_r       <= '0;
            zero      <= 1'b0;
            op_q      <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            q         <= '0;
            d         <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (start_iter) begin
                    op_q <= op;
                    cnt  <= '0;
                    neg  <= neg_in;
                    acc  <= '0;
                    q    <= mag_a;
                    d    <= mag_b;
                end else if (accept) begin
                    c_r       <= res1;
                    zero      <= (res1 == '0);
                    out_valid <= 1'b1;
                end
            end else if (!bus.flush) begin
                cnt <= cnt + 1'b1;
                acc <= acc_n;
                q   <= q_n;
                if (step_last) begin
                    c_r       <= fin;
                    zero      <= (fin == '0);
                    out_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = (state == ITER);
    assign bus.in_ready  = (state != ITER);
    assign bus.out_valid = out_valid;
    assign bus.C         = c_r;
    assign bus.Zero      = zero;
endmodule

// File: tb/tb_mc_alu.sv
// Directed-vector bench for mc_alu at WIDTH=32 and WIDTH=8.
module tb_mc_alu;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mc_alu_if #(.WIDTH(32)) bus32();
    mc_alu_if #(.WIDTH(8))  bus8();

    mc_alu #(.WIDTH(32)) dut32 (.clk(clk), .rstn(rstn), .bus(bus32));
    mc_alu #(.WIDTH(8))  dut8  (.clk(clk), .rstn(rstn), .bus(bus8));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op at the next edge, then wait (bounded) for out_valid.
    // lat = edges after the accepting edge; bsy = sampled cycles with busy high.
    task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] c, output int lat, output int bsy);
        bus32.ALUOp = op; bus32.A = a; bus32.B = b; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 0; bsy = 0;
        while (!bus32.out_valid && lat < 100) begin
            if (bus32.busy) bsy++;
            @(posedge clk); #1;
            lat++;
        end
        c = bus32.C;
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] c_prev;
        int lat, bsy, nov;

        bus32.in_valid = 1'b0; bus32.flush = 1'b0; bus32.A = '0; bus32.B = '0; bus32.ALUOp = '0;
        bus8.in_valid  = 1'b0; bus8.flush  = 1'b0; bus8.A  = '0; bus8.B  = '0; bus8.ALUOp  = '0;
        #12;
        chk("rst_c", bus32.C, 0);
        chk("rst_zero", bus32.Zero, 0);
        chk("rst_ov", bus32.out_valid, 0);
        chk("rst_busy", bus32.busy, 0);
        chk("rst_ready", bus32.in_ready, 1);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back single-cycle stream
        bus32.in_valid = 1'b1;
        bus32.ALUOp = 5'd3; bus32.A = 32'd5; bus32.B = 32'hFFFF_FFFB;
        @(posedge clk); #1;
        chk("add_c", bus32.C, 0); chk("add_zero", bus32.Zero, 1); chk("add_ov", bus32.out_valid, 1);
        bus32.ALUOp = 5'd4; bus32.A = 32'd3; bus32.B = 32'd7;
        @(posedge clk); #1;
        chk("sub_c", bus32.C, 32'hFFFF_FFFC); chk("sub_ov", bus32.out_valid, 1);
        bus32.ALUOp = 5'd10; bus32.A = 32'h8000_0000; bus32.B = 32'd4;
        @(posedge clk); #1;
        chk("sra_c", bus32.C, 32'hF800_0000); chk("sra_ov", bus32.out_valid, 1);
        bus32.ALUOp = 5'd25; bus32.A = 32'd0; bus32.B = 32'd0;
        @(posedge clk); #1;
        chk("op25_c", bus32.C, 32'hFFFF_FFFF); chk("op25_zero", bus32.Zero, 0);
        chk("op25_ov", bus32.out_valid, 1);
        bus32.ALUOp = 5'd7; bus32.A = 32'd1; bus32.B = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("sltu_c", bus32.C, 1);
        bus32.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_ov", bus32.out_valid, 0);

        // Multiply
        run32(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, lat, bsy);
        chk("mulh_c", c, 0); chk("mulh_lat", lat, 32); chk("mulh_busy", bsy, 32);
        run32(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, lat, bsy);
        chk("mulhu_c", c, 32'hFFFF_FFFE); chk("mulhu_lat", lat, 32); chk("mulhu_busy", bsy, 32);
        run32(5'd13, 32'hFFFF_FFFD, 32'd7, c, lat, bsy);
        chk("mul_c", c, 32'hFFFF_FFEB);
        run32(5'd15, 32'hFFFF_FFFF, 32'd2, c, lat, bsy);
        chk("mulhsu_c", c, 32'hFFFF_FFFF);

        // Divide corners and iterative divides
        run32(5'd17, 32'd7, 32'd0, c, lat, bsy);
        chk("div0_c", c, 32'hFFFF_FFFF); chk("div0_lat", lat, 0);
        run32(5'd19, 32'd7, 32'd0, c, lat, bsy);
        chk("rem0_c", c, 7); chk("rem0_lat", lat, 0);
        run32(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, c, lat, bsy);
        chk("divovf_c", c, 32'h8000_0000); chk("divovf_lat", lat, 0);
        run32(5'd19, 32'hFFFF_FFF9, 32'd2, c, lat, bsy);
        chk("rem_c", c, 32'hFFFF_FFFF); chk("rem_lat", lat, 32);
        run32(5'd17, 32'hFFFF_FF9C, 32'd7, c, lat, bsy);
        chk("div_c", c, 32'hFFFF_FFF2);
        run32(5'd18, 32'd100, 32'd7, c, lat, bsy);
        chk("divu_c", c, 14);

        // Flush at step 10 of a divu, then add next cycle
        c_prev = bus32.C;
        bus32.ALUOp = 5'd18; bus32.A = 32'd1000; bus32.B = 32'd3; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        nov = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus32.out_valid) nov++;
        end
        chk("flush_busy_pre", bus32.busy, 1);
        bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.flush = 1'b0;
        if (bus32.out_valid) nov++;
        chk("flush_busy", bus32.busy, 0);
        chk("flush_c_held", bus32.C, c_prev);
        chk("flush_no_ov", nov, 0);
        run32(5'd3, 32'd1, 32'd1, c, lat, bsy);
        chk("flush_add_c", c, 2); chk("flush_add_lat", lat, 0);

        // Flush with in_valid in IDLE: nothing accepted
        bus32.flush = 1'b1; bus32.in_valid = 1'b1; bus32.ALUOp = 5'd3; bus32.A = 32'd3; bus32.B = 32'd3;
        @(posedge clk); #1;
        bus32.flush = 1'b0; bus32.in_valid = 1'b0;
        chk("flushidle_ov", bus32.out_valid, 0);
        chk("flushidle_c", bus32.C, 2);
        chk("flushidle_busy", bus32.busy, 0);

        // Reset in the middle of an iteration
        bus32.ALUOp = 5'd18; bus32.A = 32'd50; bus32.B = 32'd5; bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_busy_pre", bus32.busy, 1);
        rstn = 1'b0;
        #1;
        chk("midrst_c", bus32.C, 0);
        chk("midrst_busy", bus32.busy, 0);
        chk("midrst_ready", bus32.in_ready, 1);
        chk("midrst_ov", bus32.out_valid, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        nov = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.out_valid) nov++;
        end
        chk("postrst_ready", bus32.in_ready, 1);
        chk("postrst_no_ov", nov, 0);

        // WIDTH=8 instance
        bus8.ALUOp = 5'd16; bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w8_mulhu_c", bus8.C, 8'hFE);
        chk("w8_mulhu_lat", lat, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
